wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback-side producer for the 32x32 register file's single write port (WE3/A3/WD3), with registered outputs. Merges two sources:
- the in-order pipeline writeback (source A, never stalls);
- a multi-cycle unit, such as a load or divide unit, through a valid/ready FIFO (source B).

It also keeps a per-register pending scoreboard for outstanding source-B destinations. Decode uses this scoreboard to stall on RAW hazards.

Parameters:
XLEN, 32, data width of register-file write data
B_DEPTH, 4, source-B FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-low reset, sampled on rising edge of clk
a_valid  input  1  pipeline writeback valid this cycle
a_rd  input  5  pipeline destination register
a_data  input  XLEN  pipeline result
b_valid  input  1  multi-cycle result valid
b_ready  output  1  FIFO can accept (= not full)
b_rd  input  5  multi-cycle destination register
b_data  input  XLEN  multi-cycle result
iss_valid  input  1  multi-cycle op issued this cycle
iss_rd  input  5  its destination register
rs1  input  5  decode source register 1
rs2  input  5  decode source register 2
stall  output  1  busy[rs1] | busy[rs2], combinational
WE3  output  1  register-file write enable (registered)
A3  output  5  register-file write address (registered)
WD3  output  XLEN  register-file write data (registered)

Behaviour:
- Reset (rst=0 at posedge clk):
  - FIFO emptied, occupancy=0; all busy bits cleared.
  - WE3=0, A3=0, WD3=0.
  - b_ready=1 from the first cycle after reset. Reset mid-operation discards queued B results and pending busy state.
- Source A claims the port when a_valid=1 and a_rd!=0. Next edge: WE3=1, A3=a_rd, WD3=a_data. Latency is 1 cycle; A is never delayed.
- a_valid with a_rd=0 does not claim the port. The same cycle may then drain B.
- B push: on b_valid && b_ready, {b_rd,b_data} is written at the FIFO tail.
  - b_ready = (occupancy != B_DEPTH). It does not depend on a same-cycle pop.
- B pop: when A does not claim the port and occupancy>0, the head is popped. Next edge: WE3=(head_rd!=0), A3=head_rd, WD3=head_data.
- No bypass: a B result always takes at least 2 cycles from push to WE3.
- Simultaneous push and pop: both occur and occupancy is unchanged. Pointers wrap modulo B_DEPTH.
- In cycles with no claim and an empty FIFO: WE3=0, and A3/WD3 hold their previous values.
- B results are written in push order. A is strictly higher priority, so B can be starved by back-to-back A writes. This is acceptable; the FIFO backpressures via b_ready.
- Scoreboard (32 busy bits, busy[0] hard-wired 0):
  - Set: iss_valid && iss_rd!=0 sets busy[iss_rd] at the edge.
  - Clear: a B pop with head_rd!=0 clears busy[head_rd] at the same edge the write is registered.
  - Same register set and cleared in one cycle: set wins.
  - A writes never touch busy bits. Upstream must stall A on WAW using stall.
- stall is combinational from current busy bits and rs1/rs2. It is not forwarded from same-cycle iss_valid.
- Occupancy counter width is $clog2(B_DEPTH)+1; pointer width is $clog2(B_DEPTH).

Decomposition:
- Shared package riscv_pkg holds: XLEN, REG_ADDR_W=5, NUM_REGS=32, and wb_entry_t as a packed {rd, data}.
- One sub-module, wb_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised by width and depth, with the same synchronous active-low rst.
- The arbitration, output registers and scoreboard stay in wb_arbiter.

Test Plan:
1. A-only writeback: a_valid=1, a_rd=5, a_data=0xDEADBEEF for 1 cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; the cycle after, WE3=0.
2. B path with a scoreboard round-trip:
   - Stimulus: iss_valid, iss_rd=7, then stall checked with rs1=7; two cycles later b_valid, b_rd=7, b_data=0x1234, with A idle.
   - Expected: stall=1 from the cycle after issue; WE3=1, A3=7, WD3=0x1234 two cycles after the push; stall=0 the cycle after that write.
3. Contention:
   - Stimulus: push B (rd=3, 0xAA) while A writes rd=4 (0xBB) for 3 consecutive cycles.
   - Expected: A3=4 for three cycles, then A3=3, WD3=0xAA on the 4th; FIFO order is preserved.
4. Full/backpressure:
   - Stimulus: hold a_valid=1, a_rd=1 and push 4 B results.
   - Expected: b_ready=0 after the 4th push; a 5th b_valid is not accepted.
   - Then drop a_valid: 4 sequential writes in push order; b_ready returns to 1 after the first pop.
5. x0 handling:
   - a_valid with a_rd=0 while FIFO holds rd=9 -> B pops that cycle (A3=9).
   - A B entry with rd=0 pops with WE3=0.
   - iss_rd=0 never raises stall.
6. Reset mid-operation: FIFO holding 3 entries plus busy[2]=1, assert rst=0 for 1 cycle -> WE3=0, A3=0, WD3=0, b_ready=1, stall=0 for rs1=2, and no stale writes afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file constants and the writeback entry format used by the
// writeback arbiter and its source-B queue.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // One queued multi-cycle result: destination register plus its data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with push/pop/full/empty and a look-ahead head output.
// Pushing while full and popping while empty are ignored.
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy alone decides which entries are valid.
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback (A) has strict
// priority over queued multi-cycle results (B). Also tracks which registers
// still await a B result so decode can stall on RAW hazards.
module wb_arbiter #(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int B_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            a_valid,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]                 a_data,
    input  logic                            b_valid,
    output logic                            b_ready,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]                 b_data,
    input  logic                            iss_valid,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] iss_rd,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] rs1,
    input  logic [riscv_pkg::REG_ADDR_W-1:0] rs2,
    output logic                            stall,
    output logic                            WE3,
    output logic [riscv_pkg::REG_ADDR_W-1:0] A3,
    output logic [XLEN-1:0]                 WD3
);

    import riscv_pkg::*;

    wb_entry_t                b_entry;
    wb_entry_t                head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     a_claim;
    logic                     b_push;
    logic                     b_pop;
    logic [NUM_REGS-1:1]      busy_q;
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_REGS-1:0]      busy_nxt;

    assign b_entry.rd   = b_rd;
    assign b_entry.data = b_data;

    // x0 writes from A are dropped, leaving the port free for B.
    assign a_claim = a_valid && (a_rd != '0);
    assign b_ready = !fifo_full;
    assign b_push  = b_valid && b_ready;
    assign b_pop   = !a_claim && !fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (B_DEPTH)
    ) u_b_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push),
        .pop   (b_pop),
        .din   (b_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    // Register the winning write; A/D hold their last value on idle cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            WE3 <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else if (a_claim) begin
            WE3 <= 1'b1;
            A3  <= a_rd;
            WD3 <= a_data;
        end else if (b_pop) begin
            WE3 <= (head.rd != '0);
            A3  <= head.rd;
            WD3 <= head.data;
        end else begin
            WE3 <= 1'b0;
        end
    end

    // Register 0 is never pending, so its busy bit is a constant zero.
    assign busy  = {busy_q, 1'b0};
    assign stall = busy[rs1] | busy[rs2];

    // Next scoreboard state: clear on a B write, then a same-cycle issue re-sets it.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments with a full default first, so no latch is inferred.
        busy_nxt = busy;
        if (b_pop && head.rd != '0) busy_nxt[head.rd] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_nxt[NUM_REGS-1:1];
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed, table-driven bench for wb_arbiter plus a hand-written
// reset-in-flight sequence.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        stall;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        rdy;
        logic        stl;
    } vec_t;

    vec_t vecs[$];

    wb_arbiter #(.XLEN(32), .B_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void add(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] s1, input logic [4:0] s2,
                                input logic we, input logic [4:0] a3, input logic [31:0] wd,
                                input logic rdy, input logic stl);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.bv = bv; v.brd = brd; v.bd = bd;
        v.iv = iv; v.ird = ird; v.s1 = s1; v.s2 = s2;
        v.we = we; v.a3 = a3; v.wd = wd; v.rdy = rdy; v.stl = stl;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [4:0] a3,
                             input logic [31:0] wd, input logic rdy, input logic stl);
        check({tag, " WE3"}, 32'(WE3), 32'(we));
        check({tag, " A3"}, 32'(A3), 32'(a3));
        check({tag, " WD3"}, WD3, wd);
        check({tag, " b_ready"}, 32'(b_ready), 32'(rdy));
        check({tag, " stall"}, 32'(stall), 32'(stl));
    endtask

    initial begin
        // Expected values are the outputs seen just after the edge that
        // samples the listed inputs (inputs still held at that point).
        //    av ard ad            bv brd bd        iv ird s1 s2   we a3 wd            rdy stl
        // A-only writeback
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 0,  0, 0,   1, 5, 32'hDEADBEEF, 1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   0, 5, 32'hDEADBEEF, 1, 0);
        // B path and scoreboard round-trip
        add(0, 0, 0,            0, 0, 0,          1, 7,  7, 0,   0, 5, 32'hDEADBEEF, 1, 1);
        add(0, 0, 0,            0, 0, 0,          0, 0,  7, 0,   0, 5, 32'hDEADBEEF, 1, 1);
        add(0, 0, 0,            1, 7, 32'h1234,   0, 0,  7, 0,   0, 5, 32'hDEADBEEF, 1, 1);
        add(0, 0, 0,            0, 0, 0,          0, 0,  7, 0,   1, 7, 32'h1234,     1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  7, 0,   0, 7, 32'h1234,     1, 0);
        // Contention: A holds the port three cycles, B drains afterwards in order
        add(1, 4, 32'hBB,       1, 3, 32'hAA,     0, 0,  0, 0,   1, 4, 32'hBB,       1, 0);
        add(1, 4, 32'hBB,       1, 6, 32'hCC,     0, 0,  0, 0,   1, 4, 32'hBB,       1, 0);
        add(1, 4, 32'hBB,       0, 0, 0,          0, 0,  0, 0,   1, 4, 32'hBB,       1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 3, 32'hAA,       1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 6, 32'hCC,       1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   0, 6, 32'hCC,       1, 0);
        // Fill the FIFO under continuous A traffic; the 5th push is refused
        add(1, 1, 32'h11,       1, 10, 32'h100,   0, 0,  0, 0,   1, 1, 32'h11,       1, 0);
        add(1, 1, 32'h11,       1, 11, 32'h101,   0, 0,  0, 0,   1, 1, 32'h11,       1, 0);
        add(1, 1, 32'h11,       1, 12, 32'h102,   0, 0,  0, 0,   1, 1, 32'h11,       1, 0);
        add(1, 1, 32'h11,       1, 13, 32'h103,   0, 0,  0, 0,   1, 1, 32'h11,       0, 0);
        add(1, 1, 32'h11,       1, 14, 32'h104,   0, 0,  0, 0,   1, 1, 32'h11,       0, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 10, 32'h100,     1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 11, 32'h101,     1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 12, 32'h102,     1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   1, 13, 32'h103,     1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   0, 13, 32'h103,     1, 0);
        // x0 handling
        add(0, 0, 0,            1, 9, 32'h99,     0, 0,  0, 0,   0, 13, 32'h103,     1, 0);
        add(1, 0, 32'h55,       0, 0, 0,          0, 0,  0, 0,   1, 9, 32'h99,       1, 0);
        add(0, 0, 0,            1, 0, 32'h77,     0, 0,  0, 0,   0, 9, 32'h99,       1, 0);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 0,   0, 0, 32'h77,       1, 0);
        add(0, 0, 0,            0, 0, 0,          1, 0,  0, 0,   0, 0, 32'h77,       1, 0);
        // Set wins over a same-cycle clear of the same register; rs2 path
        add(0, 0, 0,            0, 0, 0,          1, 8,  8, 0,   0, 0, 32'h77,       1, 1);
        add(0, 0, 0,            1, 8, 32'h88,     0, 0,  8, 0,   0, 0, 32'h77,       1, 1);
        add(0, 0, 0,            0, 0, 0,          1, 8,  8, 0,   1, 8, 32'h88,       1, 1);
        add(0, 0, 0,            0, 0, 0,          0, 0,  8, 0,   0, 8, 32'h88,       1, 1);
        add(0, 0, 0,            0, 0, 0,          0, 0,  0, 8,   0, 8, 32'h88,       1, 1);
        add(0, 0, 0,            0, 0, 0,          0, 0,  3, 4,   0, 8, 32'h88,       1, 0);

        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        check_all("reset", 0, 0, 0, 1, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bd;
            iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
            rs1 = vecs[i].s1; rs2 = vecs[i].s2;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].a3, vecs[i].wd,
                      vecs[i].rdy, vecs[i].stl);
        end

        // Reset with three B entries queued behind A and busy[2] set.
        for (int k = 0; k < 3; k++) begin
            a_valid = 1; a_rd = 1; a_data = 32'h22;
            b_valid = 1; b_rd = 5'(20 + k); b_data = 32'(32'h200 + k);
            iss_valid = (k == 0); iss_rd = 2;
            rs1 = 2; rs2 = 0;
            tick();
        end
        check_all("pre-reset", 1, 1, 32'h22, 1, 1);
        idle_inputs();
        rs1 = 2; rs2 = 8;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_all("mid-reset", 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all($sformatf("post-reset%0d", k), 0, 0, 0, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
